rr_priority_arbiter8: RTL and testbench
=======================================

Name: rr_priority_arbiter8

Overview:
- Arbitrates one shared resource among 8 requesters.
- Chooses a winner using the team's 8-to-3 priority-encode convention: the lowest index wins, with an optional rotating start point for fairness.
- Holds the grant until the owner releases it or a hold timeout expires.
- Sits between requester agents and the shared datapath; drives the one-hot select and the encoded owner ID.

Parameters:
- ROUND_ROBIN, 1, 1 = rotating priority starting at the index after the last owner; 0 = fixed priority, bit 0 highest.
- MAX_HOLD, 16, maximum consecutive grant cycles before a forced release; 0 = no timeout; legal range 0..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req  input  8  request vector; bit i = requester i wants the resource
- done  input  1  owner releases the resource; sampled only while gnt_valid=1
- gnt  output  8  registered one-hot grant; all zero when no owner
- gnt_id  output  3  registered binary index of the owner; 0 when no owner
- gnt_valid  output  1  registered; 1 while a grant is active
- timeout  output  1  registered one-cycle pulse on a forced release

Behaviour:
- All state is updated only on the rising edge of clk. Reset is sampled on that edge.
- Reset (rst_n=0 at the edge):
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - Rotation pointer ptr=0, hold counter hcnt=0, state=IDLE.
  - Reset dominates every other input, including reset asserted mid-grant. The grant drops on the next edge with no timeout pulse.
- The FSM has 3 states: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0, pick the winner w and go to GRANT.
  - ROUND_ROBIN=1: w is the first set bit scanning ptr, ptr+1, ... 7, 0, ... ptr-1 (mod 8).
  - ROUND_ROBIN=0: w is the lowest set index.
  - Registered outputs: gnt=1<<w, gnt_id=w, gnt_valid=1, hcnt=1.
  - Latency from req assertion (sampled at edge k) to grant visible is 1 cycle (after edge k).
  - If req == 0, stay in IDLE with outputs at zero.
- GRANT, per edge, with release conditions evaluated in priority order:
  - (a) done=1 -> release.
  - (b) req[gnt_id]=0 -> release (requester withdrew).
  - (c) MAX_HOLD != 0 and hcnt == MAX_HOLD -> forced release; timeout=1 for exactly that one following cycle.
  - Otherwise keep the grant and set hcnt=hcnt+1, saturating at 255.
  - On any release, on the same edge:
    - gnt=0, gnt_id=0, gnt_valid=0.
    - ptr=(gnt_id+1) mod 8 (3-bit wrap, so 7 -> 0).
    - hcnt=0; go to GAP.
  - If done and the timeout condition coincide, release via done and timeout stays 0.
- GAP:
  - Exactly one mandatory idle cycle with all grant outputs 0.
  - On the next edge, behave exactly as IDLE, re-arbitrating with the updated ptr. The same requester may win again if it is the only one requesting.
- Changes to req bits other than the owner's have no effect during GRANT.
- done while gnt_valid=0 is ignored.
- timeout is cleared at every edge where it is not being set.
- Invariants that always hold:
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - gnt == (gnt_valid ? 1<<gnt_id : 0).

Test Plan:
1. Reset and first grant: reset with req=8'hFF, release reset, ROUND_ROBIN=1 -> gnt=8'h01 and gnt_id=0 one cycle after the first active edge. Pulse done -> outputs 0 for one GAP cycle, then gnt=8'h02, gnt_id=1.
2. Rotation and wrap: req=8'h81 held, done pulsed every grant -> grant sequence is 0, 7, 0, 7 with a one-cycle gap between each. Repeat with ROUND_ROBIN=0 -> grant is always 0.
3. Timeout: MAX_HOLD=4, req=8'h10 held, done=0 -> gnt_id=4 for exactly 4 cycles, timeout=1 on the first cycle outputs drop, then regrant to 4 after the GAP.
4. Withdrawal and coincidence: owner 3 drops req[3] -> release on the next edge with timeout=0. With MAX_HOLD=4, assert done on the cycle hcnt=4 -> release with timeout=0.
5. Reset mid-grant: rst_n=0 while gnt_id=5 -> all outputs 0 after that edge. After reset, req=8'hFF -> grant goes to 0, confirming ptr was reset.
6. Randomized 10k cycles: random req and done -> checker confirms the invariants, no starvation (any held request is granted within 8 grants when ROUND_ROBIN=1), and grant duration is never more than MAX_HOLD.

Source files
------------

// File: rtl/rr_priority_arbiter8.sv
// Eight-way arbiter for one shared resource: lowest-index priority encode with an
// optional rotating start point, grant held until release, withdrawal or hold timeout.
module rr_priority_arbiter8 #(
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned MAX_HOLD    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [7:0] LP_MAX_HOLD = 8'(MAX_HOLD);
  localparam bit         LP_RR       = (ROUND_ROBIN != 0);
  localparam bit         LP_TO_EN    = (MAX_HOLD != 0);

  logic [1:0] r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_hcnt;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_id;
  logic       r_gnt_valid;
  logic       r_timeout;

  logic [2:0] w_base;
  logic [7:0] w_rot;
  logic [2:0] w_off;
  logic [2:0] w_win;
  logic       w_owner_req;
  logic       w_hold_hit;
  logic       w_release;

  // Rotate the request vector so the start point sits at bit 0, then take the
  // lowest set bit; the winner is that offset added back onto the start point.
  always_comb begin
    w_base = LP_RR ? r_ptr : 3'd0;
    w_rot  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_rot[i] = req[w_base + 3'(i)];
    end
    w_off = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (w_rot[i-1]) w_off = 3'(i - 1);
    end
  end

  assign w_win       = w_base + w_off;
  assign w_owner_req = req[r_gnt_id];
  assign w_hold_hit  = LP_TO_EN && (r_hcnt == LP_MAX_HOLD);
  assign w_release   = done || !w_owner_req || w_hold_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_hcnt      <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_GRANT: begin
          if (w_release) begin
            // done and withdrawal take precedence, so the pulse marks only a pure timeout
            r_timeout   <= !done && w_owner_req && w_hold_hit;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= r_gnt_id + 3'd1;
            r_hcnt      <= '0;
            r_state     <= S_GAP;
          end else if (r_hcnt != 8'hFF) begin
            r_hcnt <= r_hcnt + 8'd1;
          end
        end
        default: begin
          if (|req) begin
            r_gnt       <= 8'd1 << w_win;
            r_gnt_id    <= w_win;
            r_gnt_valid <= 1'b1;
            r_hcnt      <= 8'd1;
            r_state     <= S_GRANT;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_priority_arbiter8.sv
// Bench for rr_priority_arbiter8: directed vectors feed a scoreboard queue, a monitor
// pops and compares each cycle and also checks invariants, hold length and fairness.
module tb_rr_priority_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       done = 1'b0;

  logic [7:0] gnt_rr, gnt_fp;
  logic [2:0] id_rr, id_fp;
  logic       v_rr, v_fp, to_rr, to_fp;

  always #5 clk = ~clk;

  rr_priority_arbiter8 #(.ROUND_ROBIN(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_rr), .gnt_id(id_rr), .gnt_valid(v_rr), .timeout(to_rr)
  );

  rr_priority_arbiter8 #(.ROUND_ROBIN(0), .MAX_HOLD(4)) u_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_fp), .gnt_id(id_fp), .gnt_valid(v_fp), .timeout(to_fp)
  );

  typedef struct {
    bit         sel;   // 0 = round-robin instance, 1 = fixed-priority instance
    logic [7:0] gnt;
    logic [2:0] id;
    logic       to;
    string      nm;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  int unsigned dur[2];
  int unsigned wt[8];
  logic        pv_rr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are sampled 1ns after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [7:0] g;
      logic [2:0] id;
      logic       v, t;
      g  = (d == 0) ? gnt_rr : gnt_fp;
      id = (d == 0) ? id_rr  : id_fp;
      v  = (d == 0) ? v_rr   : v_fp;
      t  = (d == 0) ? to_rr  : to_fp;
      chk("inv_onehot0", 32'($onehot0(g)), 32'd1);
      chk("inv_valid_or", 32'(v), 32'(|g));
      chk("inv_gnt_id", 32'(g), v ? 32'(8'd1 << id) : 32'd0);
      if (t) chk("timeout_after_max_hold", {dur[d] == 4, v}, 32'b10);
      if (v) begin
        dur[d]++;
        chk("hold_le_max", 32'(dur[d] <= 4), 32'd1);
      end else begin
        dur[d] = 0;
      end
    end

    for (int i = 0; i < 8; i++) begin
      if (!rst_n || !req[i]) begin
        wt[i] = 0;
      end else if (v_rr && !pv_rr) begin
        if (32'(id_rr) == i) begin
          wt[i] = 0;
        end else begin
          wt[i]++;
          chk("starvation", 32'(wt[i] <= 7), 32'd1);
        end
      end
    end
    pv_rr = v_rr;

    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (!e.sel) begin
        chk({e.nm, ".gnt"},       32'(gnt_rr), 32'(e.gnt));
        chk({e.nm, ".gnt_id"},    32'(id_rr),  32'(e.id));
        chk({e.nm, ".gnt_valid"}, 32'(v_rr),   32'(|e.gnt));
        chk({e.nm, ".timeout"},   32'(to_rr),  32'(e.to));
      end else begin
        chk({e.nm, ".gnt"},       32'(gnt_fp), 32'(e.gnt));
        chk({e.nm, ".gnt_id"},    32'(id_fp),  32'(e.id));
        chk({e.nm, ".gnt_valid"}, 32'(v_fp),   32'(|e.gnt));
        chk({e.nm, ".timeout"},   32'(to_fp),  32'(e.to));
      end
    end
  end

  // Drive inputs for the next rising edge and queue the outputs expected after it.
  task automatic step(input logic rn, input logic [7:0] rq, input logic dn, input bit sel,
                      input logic [7:0] eg, input logic [2:0] eid, input logic eto,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = rn;
    req   = rq;
    done  = dn;
    e.sel = sel;
    e.gnt = eg;
    e.id  = eid;
    e.to  = eto;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  localparam bit RR = 1'b0;
  localparam bit FP = 1'b1;

  initial begin
    // Reset and first grant
    step(0, 8'hFF, 0, RR, 8'h00, 0, 0, "reset0");
    step(0, 8'hFF, 0, RR, 8'h00, 0, 0, "reset1");
    step(1, 8'hFF, 0, RR, 8'h01, 0, 0, "first_grant");
    step(1, 8'hFF, 1, RR, 8'h00, 0, 0, "done_gap");
    step(1, 8'hFF, 0, RR, 8'h02, 1, 0, "rotate_to_1");
    step(1, 8'hFF, 1, RR, 8'h00, 0, 0, "done_gap1");

    // Rotation and wrap, round-robin
    step(0, 8'h00, 0, RR, 8'h00, 0, 0, "reset_rot");
    step(1, 8'h81, 0, RR, 8'h01, 0, 0, "rot_a0");
    step(1, 8'h81, 1, RR, 8'h00, 0, 0, "rot_gap_a");
    step(1, 8'h81, 0, RR, 8'h80, 7, 0, "rot_b7");
    step(1, 8'h81, 1, RR, 8'h00, 0, 0, "rot_gap_b");
    step(1, 8'h81, 0, RR, 8'h01, 0, 0, "rot_wrap0");
    step(1, 8'h81, 1, RR, 8'h00, 0, 0, "rot_gap_c");
    step(1, 8'h81, 0, RR, 8'h80, 7, 0, "rot_d7");
    step(1, 8'h81, 1, RR, 8'h00, 0, 0, "rot_gap_d");

    // Same pattern, fixed priority
    step(0, 8'h00, 0, FP, 8'h00, 0, 0, "fp_reset");
    step(1, 8'h81, 0, FP, 8'h01, 0, 0, "fp_a0");
    step(1, 8'h81, 1, FP, 8'h00, 0, 0, "fp_gap_a");
    step(1, 8'h81, 0, FP, 8'h01, 0, 0, "fp_b0");
    step(1, 8'h81, 1, FP, 8'h00, 0, 0, "fp_gap_b");
    step(1, 8'h81, 0, FP, 8'h01, 0, 0, "fp_c0");
    step(1, 8'h81, 1, FP, 8'h00, 0, 0, "fp_gap_c");
    step(1, 8'h0C, 0, FP, 8'h04, 2, 0, "fp_lowest2");
    step(1, 8'h0C, 1, FP, 8'h00, 0, 0, "fp_gap_d");
    step(1, 8'h0C, 0, FP, 8'h04, 2, 0, "fp_lowest2_again");

    // Hold timeout at MAX_HOLD=4
    step(0, 8'h00, 0, RR, 8'h00, 0, 0, "to_reset");
    step(1, 8'h10, 0, RR, 8'h10, 4, 0, "to_hold1");
    step(1, 8'h10, 0, RR, 8'h10, 4, 0, "to_hold2");
    step(1, 8'h10, 0, RR, 8'h10, 4, 0, "to_hold3");
    step(1, 8'h10, 0, RR, 8'h10, 4, 0, "to_hold4");
    step(1, 8'h10, 0, RR, 8'h00, 0, 1, "to_forced");
    step(1, 8'h10, 0, RR, 8'h10, 4, 0, "to_regrant");
    step(1, 8'h10, 1, RR, 8'h00, 0, 0, "to_done");

    // Withdrawal (ptr=5 here, only requester 3)
    step(1, 8'h08, 0, RR, 8'h08, 3, 0, "wd_grant3");
    step(1, 8'h08, 0, RR, 8'h08, 3, 0, "wd_hold3");
    step(1, 8'h00, 0, RR, 8'h00, 0, 0, "wd_release");
    step(1, 8'h00, 0, RR, 8'h00, 0, 0, "wd_idle");

    // done coinciding with hcnt==MAX_HOLD (ptr=4)
    step(1, 8'h04, 0, RR, 8'h04, 2, 0, "co_h1");
    step(1, 8'h04, 0, RR, 8'h04, 2, 0, "co_h2");
    step(1, 8'h04, 0, RR, 8'h04, 2, 0, "co_h3");
    step(1, 8'h04, 0, RR, 8'h04, 2, 0, "co_h4");
    step(1, 8'h04, 1, RR, 8'h00, 0, 0, "co_done_wins");

    // Reset mid-grant (ptr=3, requester 5)
    step(1, 8'h20, 0, RR, 8'h20, 5, 0, "mid_grant5");
    step(0, 8'hFF, 0, RR, 8'h00, 0, 0, "mid_reset");
    step(1, 8'hFF, 0, RR, 8'h01, 0, 0, "post_reset_ptr0");
    step(1, 8'hFF, 1, RR, 8'h00, 0, 0, "post_reset_gap");
    step(1, 8'hFF, 0, RR, 8'h02, 1, 0, "post_reset_next1");

    // Random traffic: invariants, hold bound and fairness are checked by the monitor
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      rst_n = 1'b1;
      if ((c % 1000) < 600) req = 8'($urandom) | 8'($urandom);
      else                  req = 8'($urandom) & 8'($urandom);
      done = ($urandom_range(0, 7) == 0);
    end

    @(negedge clk);
    req  = '0;
    done = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
